// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//
// Fetch-side branch predictor. It holds a direct-mapped BTB whose entries have
// a valid bit, a tag, a 2-bit saturating direction counter and a branch
// target. It also keeps branch and mispredict statistics counters.
//
// The IF-stage PC is looked up combinationally with zero latency. The resolved
// outcome from the branch zero test (res_*) trains the table at the next
// rising edge. The mispredict flush and its redirect PC are raised in the
// same cycle that the branch resolves.
//
// Ports
//   clk              system clock; all state changes on the rising edge
//   reset            synchronous, active-high reset
//   if_pc            fetch PC under lookup
//   pred_taken       predicted taken for if_pc
//   pred_target      predicted next PC for if_pc
//   res_valid        a branch resolves this cycle (one cycle per branch)
//   res_pc           PC of the resolving branch
//   res_taken        actual outcome (Z from the zero test)
//   res_target       computed branch target
//   res_pred_taken   prediction carried down the pipe with this branch
//   res_pred_target  predicted next PC carried down the pipe
//   mispredict       flush request, same cycle as res_valid
//   redirect_pc      correct next PC (always driven)
//   stat_branches    saturating resolved-branch count
//   stat_mispredicts saturating mispredict count
// -----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Table state
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  valid_d;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [1:0]          ctr_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];

    // Statistics
    logic [31:0] stat_branches_q;
    logic [31:0] stat_branches_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    // Lookup / resolve helpers
    logic [INDEX_BITS-1:0] if_idx_s;
    logic [TAG_BITS-1:0]   if_tag_s;
    logic                  if_hit_s;
    logic [INDEX_BITS-1:0] res_idx_s;
    logic [TAG_BITS-1:0]   res_tag_s;
    logic                  res_hit_s;

    function automatic logic [INDEX_BITS-1:0] pc_index(input logic [31:0] pc);
        return pc[INDEX_BITS+1:2];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] pc);
        return pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    endfunction

    // 2-bit saturating counter step toward the observed direction
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        case ({taken, c})
            3'b1_11: n = 2'b11;
            3'b0_00: n = 2'b00;
            3'b1_00,
            3'b1_01,
            3'b1_10: n = c + 2'b01;
            3'b0_01,
            3'b0_10,
            3'b0_11: n = c - 2'b01;
            default: n = c;
        endcase
        return n;
    endfunction

    // Fetch lookup: reads pre-edge contents only, no bypass from the update path
    always_comb begin
        if_idx_s    = pc_index(if_pc);
        if_tag_s    = pc_tag(if_pc);
        if_hit_s    = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
        pred_taken  = if_hit_s && ctr_q[if_idx_s][1];
        if (pred_taken) begin
            pred_target = target_q[if_idx_s];
        end else begin
            pred_target = if_pc + 32'd4;
        end
    end

    // Resolution check: flush request and the corrected fetch address
    always_comb begin
        mispredict = res_valid &&
                     ((res_taken != res_pred_taken) ||
                      (res_taken && (res_target != res_pred_target)));
        if (res_taken) begin
            redirect_pc = res_target;
        end else begin
            redirect_pc = res_pc + 32'd4;
        end
    end

    // Next-state for table entries and statistics
    always_comb begin
        valid_d            = valid_q;
        tag_d              = tag_q;
        ctr_d              = ctr_q;
        target_d           = target_q;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        res_idx_s          = pc_index(res_pc);
        res_tag_s          = pc_tag(res_pc);
        res_hit_s          = valid_q[res_idx_s] && (tag_q[res_idx_s] == res_tag_s);

        if (res_valid) begin
            if (res_hit_s) begin
                ctr_d[res_idx_s] = ctr_step(ctr_q[res_idx_s], res_taken);
                if (res_taken) begin
                    target_d[res_idx_s] = res_target;
                end else begin
                    target_d[res_idx_s] = target_q[res_idx_s];
                end
            end else if (res_taken) begin
                // Taken miss replaces whatever occupies the slot, weakly taken
                valid_d[res_idx_s]  = 1'b1;
                tag_d[res_idx_s]    = res_tag_s;
                ctr_d[res_idx_s]    = 2'b10;
                target_d[res_idx_s] = res_target;
            end else begin
                // Not-taken miss: nothing worth remembering
                valid_d[res_idx_s] = valid_q[res_idx_s];
            end

            if (stat_branches_q != 32'hFFFF_FFFF) begin
                stat_branches_d = stat_branches_q + 32'd1;
            end else begin
                stat_branches_d = stat_branches_q;
            end

            if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            end else begin
                stat_mispredicts_d = stat_mispredicts_q;
            end
        end else begin
            stat_branches_d = stat_branches_q;
        end
    end

    // State registers; reset wins over a same-cycle resolve
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q            <= '0;
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                ctr_q[i]    <= 2'b01;
                target_q[i] <= 32'd0;
            end
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            ctr_q              <= ctr_d;
            target_q           <= target_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for branch_predict_unit. Each cycle the expected outputs
// are pushed to a scoreboard queue while the inputs are driven. They are popped
// and compared on the falling edge. An independent behavioural model of the
// table and counters supplies the expectations.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk             (clk),
        .reset           (reset),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } sb_item_t;
    sb_item_t sbq[$];

    // Reference model state
    bit          m_v   [64];
    logic [7:0]  m_tag [64];
    logic [1:0]  m_ctr [64];
    logic [31:0] m_tgt [64];
    logic [31:0] m_sb;
    logic [31:0] m_sm;
    bit          known = 1'b0;

    localparam logic [31:0] PC_P = 32'h0040_0010;
    localparam logic [31:0] PC_A = 32'h0040_0110;  // same index as PC_P, new tag
    localparam logic [31:0] PC_Q = 32'h0040_0020;
    localparam logic [31:0] PC_R = 32'h0040_0040;
    localparam logic [31:0] T1   = 32'h0040_0100;
    localparam logic [31:0] T2   = 32'h0040_0200;
    localparam logic [31:0] T3   = 32'h0040_0300;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic string sel_name(input int sel);
        case (sel)
            0: return "pred_taken";
            1: return "pred_target";
            2: return "mispredict";
            3: return "redirect_pc";
            4: return "stat_branches";
            default: return "stat_mispredicts";
        endcase
    endfunction

    function automatic logic [31:0] sel_actual(input int sel);
        case (sel)
            0: return {31'd0, pred_taken};
            1: return pred_target;
            2: return {31'd0, mispredict};
            3: return redirect_pc;
            4: return stat_branches;
            default: return stat_mispredicts;
        endcase
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        return m_v[pc[7:2]] && (m_tag[pc[7:2]] == pc[15:8]);
    endfunction

    function automatic logic m_pt(input logic [31:0] pc);
        return m_hit(pc) && m_ctr[pc[7:2]][1];
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[pc[7:2]] : pc + 32'd4;
    endfunction

    task automatic push(input int sel, input logic [31:0] exp);
        sb_item_t it;
        it.sel = sel;
        it.exp = exp;
        sbq.push_back(it);
    endtask

    // One clock: drive after the edge, score on the falling edge, advance model
    task automatic cyc(input logic rst, input logic [31:0] ipc, input logic rv,
                       input logic [31:0] rpc, input logic rt, input logic [31:0] rtg,
                       input logic rpt, input logic [31:0] rptg);
        logic     mis;
        logic [5:0] j;
        sb_item_t it;
        @(posedge clk);
        #1;
        reset = rst; if_pc = ipc; res_valid = rv; res_pc = rpc; res_taken = rt;
        res_target = rtg; res_pred_taken = rpt; res_pred_target = rptg;

        mis = rv && ((rt != rpt) || (rt && (rtg != rptg)));
        push(2, {31'd0, mis});
        push(3, rt ? rtg : rpc + 32'd4);
        if (known) begin
            push(0, {31'd0, m_pt(ipc)});
            push(1, m_ptgt(ipc));
            push(4, m_sb);
            push(5, m_sm);
        end

        @(negedge clk);
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            check(sel_name(it.sel), sel_actual(it.sel), it.exp);
        end

        j = rpc[7:2];
        if (rst) begin
            for (int k = 0; k < 64; k++) begin
                m_v[k] = 1'b0;
                m_ctr[k] = 2'b01;
            end
            m_sb = 32'd0;
            m_sm = 32'd0;
            known = 1'b1;
        end else if (rv) begin
            if (m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 32'd1;
            if (mis && (m_sm != 32'hFFFF_FFFF)) m_sm = m_sm + 32'd1;
            if (m_hit(rpc)) begin
                if (rt) begin
                    m_ctr[j] = (m_ctr[j] == 2'b11) ? 2'b11 : m_ctr[j] + 2'b01;
                    m_tgt[j] = rtg;
                end else begin
                    m_ctr[j] = (m_ctr[j] == 2'b00) ? 2'b00 : m_ctr[j] - 2'b01;
                end
            end else if (rt) begin
                m_v[j] = 1'b1;
                m_tag[j] = rpc[15:8];
                m_ctr[j] = 2'b10;
                m_tgt[j] = rtg;
            end
        end
    endtask

    task automatic idle(input logic [31:0] ipc);
        cyc(1'b0, ipc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    logic [31:0] pool [6];
    logic [31:0] tpool [3];

    initial begin
        reset = 1'b1; if_pc = 32'd0; res_valid = 1'b0; res_pc = 32'd0; res_taken = 1'b0;
        res_target = 32'd0; res_pred_taken = 1'b0; res_pred_target = 32'd0;
        pool  = '{PC_P, PC_A, PC_Q, PC_R, 32'h0040_1010, 32'h0040_0030};
        tpool = '{T1, T2, T3};

        // Reset, then cold lookup
        cyc(1'b1, PC_P, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        cyc(1'b1, PC_P, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(PC_P);
        check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("reset_pred_target", pred_target, 32'h0040_0014);
        check("reset_stat_br", stat_branches, 32'd0);

        // First taken resolve allocates and mispredicts
        cyc(1'b0, PC_P, 1'b1, PC_P, 1'b1, T1, 1'b0, PC_P + 32'd4);
        check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
        check("alloc_redirect", redirect_pc, T1);
        idle(PC_P);
        check("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("alloc_pred_target", pred_target, T1);
        check("alloc_stat_mis", stat_mispredicts, 32'd1);

        // Not-taken walk down: 10 -> 01 -> 00 -> 00
        cyc(1'b0, PC_P, 1'b1, PC_P, 1'b0, T1, 1'b1, T1);
        check("nt_mis_redirect", redirect_pc, PC_P + 32'd4);
        cyc(1'b0, PC_P, 1'b1, PC_P, 1'b0, T1, 1'b0, PC_P + 32'd4);
        check("nt_match_no_mis", {31'd0, mispredict}, 32'd0);
        check("nt_pred_after_first", {31'd0, pred_taken}, 32'd0);
        cyc(1'b0, PC_P, 1'b1, PC_P, 1'b0, T1, 1'b0, PC_P + 32'd4);
        // Taken walk up to 11 and hold
        for (int k = 0; k < 4; k++) cyc(1'b0, PC_P, 1'b1, PC_P, 1'b1, T1, 1'b0, PC_P + 32'd4);
        cyc(1'b0, PC_P, 1'b1, PC_P, 1'b0, T1, 1'b1, T1);
        idle(PC_P);
        check("sat_hi_one_nt_still_taken", {31'd0, pred_taken}, 32'd1);

        // Aliasing replaces the occupant
        cyc(1'b0, PC_A, 1'b1, PC_A, 1'b1, T2, 1'b0, PC_A + 32'd4);
        idle(PC_P);
        check("alias_orig_miss", {31'd0, pred_taken}, 32'd0);
        idle(PC_A);
        check("alias_new_target", pred_target, T2);

        // Same-cycle lookup/update: no bypass
        cyc(1'b0, PC_Q, 1'b1, PC_Q, 1'b1, T3, 1'b0, PC_Q + 32'd4);
        check("same_cycle_old", {31'd0, pred_taken}, 32'd0);
        idle(PC_Q);
        check("same_cycle_next", {31'd0, pred_taken}, 32'd1);
        cyc(1'b0, PC_Q, 1'b1, PC_Q, 1'b1, T3, 1'b1, 32'h0040_0304);
        check("wrong_target_mis", {31'd0, mispredict}, 32'd1);
        check("wrong_target_redirect", redirect_pc, T3);
        cyc(1'b0, PC_Q, 1'b1, PC_Q, 1'b1, T3, 1'b1, T3);
        check("right_target_no_mis", {31'd0, mispredict}, 32'd0);

        // Random traffic over a small aliasing PC pool
        for (int k = 0; k < 200; k++) begin
            logic [31:0] rp;
            logic [31:0] rtg;
            logic        rt;
            logic        rpt;
            logic [31:0] rptg;
            rp  = pool[$urandom_range(0, 5)];
            rt  = 1'($urandom_range(0, 1));
            rtg = tpool[$urandom_range(0, 2)];
            if ($urandom_range(0, 3) != 0) begin
                rpt  = m_pt(rp);
                rptg = m_ptgt(rp);
            end else begin
                rpt  = 1'($urandom_range(0, 1));
                rptg = tpool[$urandom_range(0, 2)];
            end
            cyc(1'b0, pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                rp, rt, rtg, rpt, rptg);
        end

        // Reset beats a simultaneous resolve
        cyc(1'b0, PC_P, 1'b1, PC_R, 1'b1, T1, 1'b0, PC_R + 32'd4);
        cyc(1'b1, PC_P, 1'b1, PC_R, 1'b1, T1, 1'b0, PC_R + 32'd4);
        idle(PC_R);
        check("rst_drop_lookup", {31'd0, pred_taken}, 32'd0);
        check("rst_drop_stat_br", stat_branches, 32'd0);
        check("rst_drop_stat_mis", stat_mispredicts, 32'd0);
        idle(PC_P);
        idle(PC_A);
        idle(PC_Q);

        // Saturation of the statistics counters
        force dut.stat_branches_q = 32'hFFFF_FFFE;
        force dut.stat_mispredicts_q = 32'hFFFF_FFFE;
        #1;
        release dut.stat_branches_q;
        release dut.stat_mispredicts_q;
        m_sb = 32'hFFFF_FFFE;
        m_sm = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) cyc(1'b0, PC_P, 1'b1, PC_P, 1'b1, T1, 1'b0, PC_P + 32'd4);
        idle(PC_P);
        check("stat_br_saturate", stat_branches, 32'hFFFF_FFFF);
        check("stat_mis_saturate", stat_mispredicts, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
